wb_merge: RTL

WB_MERGE -- requirements
Module: wb_merge

---
 rtl/wb_merge_if.sv | 33 +++
 rtl/wb_merge.sv | 107 ++++++++++
 2 files changed

// File: rtl/wb_merge_if.sv
// Writeback merge bus: ALU request, load handshake, register-file write port.
// master = upstream/producer side, slave = wb_merge.
interface wb_merge_if;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_stall;
   logic        ld_valid;
   logic        ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        wb_we;
   logic [4:0]  wb_wa;
   logic [31:0] wb_wd;
   logic [31:0] busy_mask;
   logic        err;

   modport master (
      output alu_valid, alu_rd, alu_data,
      output ld_valid, ld_rd, ld_data,
      input  alu_stall, ld_ready,
      input  wb_we, wb_wa, wb_wd,
      input  busy_mask, err
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  ld_valid, ld_rd, ld_data,
      output alu_stall, ld_ready,
      output wb_we, wb_wa, wb_wd,
      output busy_mask, err
   );
endinterface

// File: rtl/wb_merge.sv
// Merges single-cycle ALU writebacks with a FIFO of load writebacks onto
// one register-file write port. Ports: clk, rst_n, bus (wb_merge_if.slave).
module wb_merge #(
   parameter int DEPTH   = 4,
   parameter int AGE_MAX = 7
) (
   input  logic       clk,
   input  logic       rst_n,
   wb_merge_if.slave  bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = (AGE_MAX > 0) ? $clog2(AGE_MAX + 1) : 1;
   localparam logic [CW-1:0] FULL    = CW'(DEPTH);
   localparam logic [AW-1:0] AGE_TOP = AW'(AGE_MAX);
   localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

   logic [PW-1:0]    rd_ptr, wr_ptr;
   logic [CW-1:0]    count;
   logic [AW-1:0]    age;
   logic [DEPTH-1:0] ent_vld, ent_kill;
   logic [4:0]       ent_rd   [DEPTH];
   logic [31:0]      ent_data [DEPTH];

   logic alu_req, push, pop, head_live, head_issue;
   logic [31:0] busy;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   // A stalled cycle drops the ALU request so the head can drain.
   assign alu_req    = bus.alu_valid & ~bus.alu_stall & (bus.alu_rd != 5'd0);
   assign push       = bus.ld_valid & bus.ld_ready & (bus.ld_rd != 5'd0);
   assign head_live  = ent_vld[rd_ptr] & ~ent_kill[rd_ptr];
   // Killed heads retire silently whenever the port is free.
   assign pop        = ~alu_req & ent_vld[rd_ptr];
   assign head_issue = pop & ~ent_kill[rd_ptr];

   assign bus.ld_ready  = (count != FULL);
   assign bus.busy_mask = busy;

   always_comb begin
      busy = '0;
      for (int i = 0; i < DEPTH; i++)
         if (ent_vld[i] && !ent_kill[i])
            busy[ent_rd[i]] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         ent_rd[wr_ptr]   <= bus.ld_rd;
         ent_data[wr_ptr] <= bus.ld_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count         <= '0;
         age           <= '0;
         ent_vld       <= '0;
         ent_kill      <= '0;
         bus.wb_we     <= 1'b0;
         bus.wb_wa     <= '0;
         bus.wb_wd     <= '0;
         bus.alu_stall <= 1'b0;
         bus.err       <= 1'b0;
      end else begin
         // WAW: older queued writes to the same rd become dead.
         if (alu_req)
            for (int i = 0; i < DEPTH; i++)
               if (ent_vld[i] && ent_rd[i] == bus.alu_rd)
                  ent_kill[i] <= 1'b1;
         if (pop) begin
            ent_vld[rd_ptr]  <= 1'b0;
            ent_kill[rd_ptr] <= 1'b0;
            rd_ptr           <= nxt(rd_ptr);
         end
         // Same-cycle push is younger than the ALU write: never killed.
         if (push) begin
            ent_vld[wr_ptr]  <= 1'b1;
            ent_kill[wr_ptr] <= 1'b0;
            wr_ptr           <= nxt(wr_ptr);
         end
         count <= count + CW'(push) - CW'(pop);

         if (pop || count == '0)
            age <= '0;
         else if (age != AGE_TOP)
            age <= age + 1'b1;

         bus.alu_stall <= (age == AGE_TOP) & head_live & ~pop;
         bus.err       <= bus.err | (bus.alu_valid & bus.alu_stall);

         bus.wb_we <= alu_req | head_issue;
         if (alu_req) begin
            bus.wb_wa <= bus.alu_rd;
            bus.wb_wd <= bus.alu_data;
         end else if (head_issue) begin
            bus.wb_wa <= ent_rd[rd_ptr];
            bus.wb_wd <= ent_data[rd_ptr];
         end
      end
   end
endmodule
